// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit.
// Optional feature macro: MIPS_CTRL_TRAP_EN (illegal opcodes trap instead of acting as NOPs).
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTEXE   = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEXE = 4'd9,
    S_JUMP    = 4'd10,
    S_TRAP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // One bundle for every datapath control signal driven in a cycle
  typedef struct packed {
    logic       pc_en;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  // First execution state for a decoded opcode; bad_target is used for unknown opcodes
  function automatic state_t dispatch(input logic [5:0] op, input state_t bad_target);
    state_t nxt;
    case (op)
      OP_RTYPE:     nxt = S_RTEXE;
      OP_LW, OP_SW: nxt = S_MEMADR;
      OP_BEQ:       nxt = S_BRANCH;
      OP_ADDI:      nxt = S_ADDIEXE;
      OP_J:         nxt = S_JUMP;
      default:      nxt = bad_target;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Combinational output decoder: current state (plus opcode, mem_ready and zero)
// to the datapath control word. Optional macro: MIPS_CTRL_TRAP_EN drives illegal in TRAP.
module mips_ctrl_outdec
  import mips_ctrl_pkg::*;
#(
  parameter int op_w = 6
) (
  input  state_t          state,
  input  logic [op_w-1:0] opcode,
  input  logic            mem_ready,
  input  logic            zero,
  output ctrl_t           ctrl
);

  logic pc_write;
  logic pc_write_cond;

  // Decode the control word for the current state; pc_en merges unconditional and branch writes
  always_comb begin
    ctrl          = CTRL_IDLE;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.ir_write  = mem_ready;
        pc_write       = mem_ready;
      end
      S_DECODE: ctrl.alu_src_b = SRCB_IMM_SH2;
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_RTEXE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = (opcode == OP_RTYPE);
      end
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALUOP_SUB;
        ctrl.pc_source = PCSRC_ALUOUT;
        pc_write_cond  = 1'b1;
      end
      S_ADDIEXE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_JUMP: begin
        ctrl.pc_source = PCSRC_JUMP;
        pc_write       = 1'b1;
      end
      S_TRAP: begin
`ifdef MIPS_CTRL_TRAP_EN
        ctrl.illegal = 1'b1;
`else
        ctrl.illegal = 1'b0;
`endif
      end
      default: ctrl = CTRL_IDLE;
    endcase
    ctrl.pc_en = pc_write | (pc_write_cond & zero);
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: state register, next-state logic and retired counter.
// Optional macro: MIPS_CTRL_TRAP_EN sends illegal opcodes to a sticky TRAP state;
// without it they retire as NOPs.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int op_w  = 6,
  parameter int cnt_w = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [op_w-1:0]  opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             ir_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             iord,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [cnt_w-1:0] instr_retired
);

`ifdef MIPS_CTRL_TRAP_EN
  localparam state_t ILLEGAL_TARGET = S_TRAP;
`else
  localparam state_t ILLEGAL_TARGET = S_FETCH;
`endif

  state_t cur_state;
  state_t next_state;
  ctrl_t  ctrl_raw;
  ctrl_t  ctrl;

  mips_ctrl_outdec #(.op_w(op_w)) u_outdec (
    .state     (cur_state),
    .opcode    (opcode),
    .mem_ready (mem_ready),
    .zero      (zero),
    .ctrl      (ctrl_raw)
  );

  // Reset must silence every request immediately, even though FETCH asserts mem_read
  assign ctrl = reset ? CTRL_IDLE : ctrl_raw;

  assign pc_en      = ctrl.pc_en;
  assign ir_write   = ctrl.ir_write;
  assign mem_read   = ctrl.mem_read;
  assign mem_write  = ctrl.mem_write;
  assign iord       = ctrl.iord;
  assign reg_write  = ctrl.reg_write;
  assign reg_dst    = ctrl.reg_dst;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign pc_source  = ctrl.pc_source;
  assign illegal    = ctrl.illegal;
  assign state      = cur_state;

  // Select the next state; memory states wait on mem_ready, others ignore it
  always_comb begin
    next_state = cur_state;
    case (cur_state)
      S_FETCH:   if (mem_ready) next_state = S_DECODE; else next_state = S_FETCH;
      S_DECODE:  next_state = dispatch(opcode, ILLEGAL_TARGET);
      S_MEMADR:  if (opcode == OP_LW) next_state = S_MEMRD; else next_state = S_MEMWR;
      S_MEMRD:   if (mem_ready) next_state = S_MEMWB; else next_state = S_MEMRD;
      S_MEMWB:   next_state = S_FETCH;
      S_MEMWR:   if (mem_ready) next_state = S_FETCH; else next_state = S_MEMWR;
      S_RTEXE:   next_state = S_ALUWB;
      S_ALUWB:   next_state = S_FETCH;
      S_BRANCH:  next_state = S_FETCH;
      S_ADDIEXE: next_state = S_ALUWB;
      S_JUMP:    next_state = S_FETCH;
      S_TRAP:    next_state = S_TRAP;
      default:   next_state = S_FETCH;
    endcase
  end

  // State register and retire counter; an instruction retires on re-entry to FETCH
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_state     <= S_FETCH;
      instr_retired <= '0;
    end else begin
      cur_state <= next_state;
      if ((next_state == S_FETCH) && (cur_state != S_FETCH)) begin
        instr_retired <= instr_retired + cnt_w'(1);
      end
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl. The model describes each
// instruction as the list of states it should visit and derives every output
// column from the state number. Honours MIPS_CTRL_TRAP_EN.
`timescale 1ns/1ps
module tb_mips_multicycle_ctrl;

  localparam logic [5:0] OPC_R    = 6'b000000;
  localparam logic [5:0] OPC_LW   = 6'b100011;
  localparam logic [5:0] OPC_SW   = 6'b101011;
  localparam logic [5:0] OPC_BEQ  = 6'b000100;
  localparam logic [5:0] OPC_ADDI = 6'b001000;
  localparam logic [5:0] OPC_J    = 6'b000010;
  localparam logic [5:0] OPC_BAD  = 6'b111111;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic        pc_en, ir_write, mem_read, mem_write, iord, reg_write, reg_dst;
  logic        mem_to_reg, alu_src_a, illegal;
  logic [1:0]  alu_src_b, alu_op, pc_source;
  logic [3:0]  state;
  logic [31:0] instr_retired;

  mips_multicycle_ctrl #(.op_w(6), .cnt_w(32)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en), .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
    .iord(iord), .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
    .illegal(illegal), .state(state), .instr_retired(instr_retired)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model state
  int          retired = 0;
  logic        exp_rst = 1'b1;
  int          exp_state = 0;
  logic [14:0] exp_ctrl = 15'd0;
  logic        exp_ill = 1'b0;
  logic        chk_en = 1'b0;
  logic        tally_en = 1'b0;
  int          mw_cycles = 0;
  int          br_taken = 0;
  int          jmp_cycles = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Output columns in order: pc_en ir_write mem_read mem_write iord reg_write reg_dst
  // mem_to_reg alu_src_a alu_src_b alu_op pc_source
  function automatic logic [14:0] model_ctrl(input int s, input logic [5:0] op,
                                             input logic mr, input logic z);
    logic [1:0] srcb, aop, psrc;
    srcb = (s == 0) ? 2'b01 : (s == 1) ? 2'b11 : ((s == 2) || (s == 9)) ? 2'b10 : 2'b00;
    aop  = (s == 6) ? 2'b10 : (s == 8) ? 2'b01 : 2'b00;
    psrc = (s == 8) ? 2'b01 : (s == 10) ? 2'b10 : 2'b00;
    return {((s == 0) && mr) || ((s == 8) && z) || (s == 10),
            (s == 0) && mr,
            (s == 0) || (s == 3),
            (s == 5),
            (s == 3) || (s == 5),
            (s == 4) || (s == 7),
            (s == 7) && (op == 6'b000000),
            (s == 4),
            (s == 2) || (s == 6) || (s == 8) || (s == 9),
            srcb, aop, psrc};
  endfunction

  // Compare the DUT against the model once per cycle on the inactive edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("state", 32'(state), exp_rst ? 32'd0 : 32'(exp_state));
      check("ctrl", 32'({pc_en, ir_write, mem_read, mem_write, iord, reg_write, reg_dst,
                         mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source}),
            exp_rst ? 32'd0 : 32'(exp_ctrl));
      check("illegal", 32'(illegal), exp_rst ? 32'd0 : 32'(exp_ill));
      check("retired", instr_retired, exp_rst ? 32'd0 : 32'(retired));
      if (tally_en) begin
        if (mem_write) mw_cycles++;
        if (pc_en && (pc_source == 2'b01)) br_taken++;
        if (pc_en && (pc_source == 2'b10)) jmp_cycles++;
      end
    end
  end

  // One clock cycle in which the model expects state s
  task automatic step(input int s, input logic mr);
    mem_ready = mr;
    exp_rst   = 1'b0;
    exp_state = s;
    exp_ctrl  = model_ctrl(s, opcode, mr, zero);
    exp_ill   = (s == 11);
    chk_en    = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset     = 1'b1;
    mem_ready = 1'b1;
    zero      = 1'b1;
    exp_rst   = 1'b1;
    retired   = 0;
    chk_en    = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
  endtask

  // Walk one instruction through its expected state list
  task automatic run_instr(input logic [5:0] op, input int fstall, input int mstall, input logic z);
    opcode = op;
    zero   = z;
    repeat (fstall) step(0, 1'b0);
    step(0, 1'b1);
    step(1, 1'b0);
    case (op)
      OPC_LW: begin
        step(2, 1'b0);
        repeat (mstall) step(3, 1'b0);
        step(3, 1'b1);
        step(4, 1'b0);
      end
      OPC_SW: begin
        step(2, 1'b1);
        repeat (mstall) step(5, 1'b0);
        step(5, 1'b1);
      end
      OPC_R:    begin step(6, 1'b1); step(7, 1'b0); end
      OPC_ADDI: begin step(9, 1'b0); step(7, 1'b1); end
      OPC_BEQ:  step(8, 1'b0);
      OPC_J:    step(10, 1'b0);
      default: begin
`ifdef MIPS_CTRL_TRAP_EN
        repeat (4) step(11, 1'b1);
        return;
`endif
      end
    endcase
    retired++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    opcode    = OPC_LW;
    zero      = 1'b0;
    mem_ready = 1'b1;
    reset     = 1'b1;
    do_reset(2);

    // 1: lw, no stalls
    run_instr(OPC_LW, 0, 0, 1'b0);
    check("t1_retired", instr_retired, 32'd1);
    check("t1_state", 32'(state), 32'd0);

    // 2: sw with fetch stall and three memory stalls
    mw_cycles = 0;
    tally_en  = 1'b1;
    run_instr(OPC_SW, 1, 3, 1'b0);
    tally_en  = 1'b0;
    check("t2_mem_write_cycles", 32'(mw_cycles), 32'd4);
    check("t2_retired", instr_retired, 32'd2);

    // 3: beq taken then not taken
    br_taken = 0;
    tally_en = 1'b1;
    run_instr(OPC_BEQ, 0, 0, 1'b1);
    run_instr(OPC_BEQ, 0, 0, 1'b0);
    tally_en = 1'b0;
    check("t3_branch_pc_en", 32'(br_taken), 32'd1);
    check("t3_retired", instr_retired, 32'd4);

    // 4: R, addi, j from a fresh reset
    do_reset(1);
    jmp_cycles = 0;
    tally_en   = 1'b1;
    run_instr(OPC_R, 2, 0, 1'b0);
    run_instr(OPC_ADDI, 0, 0, 1'b1);
    run_instr(OPC_J, 0, 0, 1'b0);
    tally_en   = 1'b0;
    check("t4_jump_cycles", 32'(jmp_cycles), 32'd1);
    check("t4_retired", instr_retired, 32'd3);

    // 5: reset asserted while in MEMRD
    opcode = OPC_LW;
    zero   = 1'b0;
    step(0, 1'b1);
    step(1, 1'b0);
    step(2, 1'b0);
    check("t5_in_memrd", 32'(state), 32'd3);
    mem_ready = 1'b0;
    reset     = 1'b1;
    exp_rst   = 1'b1;
    retired   = 0;
    #1;
    check("t5_state", 32'(state), 32'd0);
    check("t5_mem_read", 32'(mem_read), 32'd0);
    check("t5_iord", 32'(iord), 32'd0);
    check("t5_retired", instr_retired, 32'd0);
    do_reset(1);
    run_instr(OPC_J, 0, 0, 1'b0);
    check("t5_resume", instr_retired, 32'd1);

    // 6: illegal opcode
    run_instr(OPC_BAD, 0, 0, 1'b0);
`ifdef MIPS_CTRL_TRAP_EN
    check("t6_trap_state", 32'(state), 32'd11);
    check("t6_illegal", 32'(illegal), 32'd1);
    check("t6_retired", instr_retired, 32'd1);
    do_reset(1);
    check("t6_cleared", 32'(illegal), 32'd0);
`else
    check("t6_nop_state", 32'(state), 32'd0);
    check("t6_retired", instr_retired, 32'd2);
    run_instr(OPC_BEQ, 0, 0, 1'b0);
    check("t6_after", instr_retired, 32'd3);
`endif

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
